// File: rtl/tdc_pulse_gen.sv
// tdc_pulse_gen: self-test initiator and result reader for the TDC core.
// Each run fires a start/stop pair spaced by the programmed delay. It then waits
// for the TDC result, acknowledges it, and scores the coarse count against the
// programmed delay minus EXPECT_OFFSET. Pass/fail statistics cover the current batch.
// Optional build macro TDC_PULSE_GEN_SWEEP_EN: the delay steps up by one after
// every run, saturating at all-ones.
//
// state      | meaning
// IDLE       | waiting for go
// ARM        | waiting for the TDC to be idle (not busy, no stale result)
// DELAY      | start issued, counting d cycles to stop
// WAIT_VALID | stop issued, waiting for the result or the timeout
// NEXT       | result acked, deciding between another run and batch end
module tdc_pulse_gen #(
  parameter int COARSE_WIDTH   = 24,
  parameter int FINE_WIDTH     = 8,
  parameter int EXPECT_OFFSET  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_fast,
  input  logic                    rst,
  input  logic                    go,
  input  logic [COARSE_WIDTH-1:0] delay_cfg,
  input  logic [15:0]             num_runs,
  output logic                    tdc_start,
  output logic                    tdc_stop,
  output logic                    tdc_ack,
  input  logic                    tdc_busy,
  input  logic                    tdc_valid,
  input  logic [COARSE_WIDTH-1:0] tdc_coarse,
  input  logic [FINE_WIDTH-1:0]   tdc_fine,
  output logic                    running,
  output logic                    done,
  output logic [15:0]             pass_count,
  output logic [15:0]             fail_count,
  output logic [COARSE_WIDTH-1:0] last_coarse,
  output logic [FINE_WIDTH-1:0]   last_fine,
  output logic                    err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COARSE_WIDTH-1:0] ONE_C   = 1;
  localparam logic [COARSE_WIDTH-1:0] EXP_OFF = COARSE_WIDTH'(EXPECT_OFFSET);
  localparam logic [15:0]             ONE_R   = 16'd1;
  localparam logic [TW-1:0]           ONE_T   = 1;
  localparam logic [TW-1:0]           T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ARM, DELAY, WAIT_VALID, NEXT} state_t;

  state_t                  state, state_nxt;
  logic [COARSE_WIDTH-1:0] d, d_nxt, dcnt, dcnt_nxt;
  logic [15:0]             runs, runs_nxt;
  logic [TW-1:0]           tcnt, tcnt_nxt;
  logic                    start_nxt, stop_nxt, ack_nxt, running_nxt, done_nxt, err_nxt;
  logic [15:0]             pass_nxt, fail_nxt;
  logic [COARSE_WIDTH-1:0] last_coarse_nxt;
  logic [FINE_WIDTH-1:0]   last_fine_nxt;

  // State, working counters and every output are registered here.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      d           <= '0;
      dcnt        <= '0;
      runs        <= '0;
      tcnt        <= '0;
      tdc_start   <= 1'b0;
      tdc_stop    <= 1'b0;
      tdc_ack     <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      pass_count  <= '0;
      fail_count  <= '0;
      last_coarse <= '0;
      last_fine   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      d           <= d_nxt;
      dcnt        <= dcnt_nxt;
      runs        <= runs_nxt;
      tcnt        <= tcnt_nxt;
      tdc_start   <= start_nxt;
      tdc_stop    <= stop_nxt;
      tdc_ack     <= ack_nxt;
      running     <= running_nxt;
      done        <= done_nxt;
      pass_count  <= pass_nxt;
      fail_count  <= fail_nxt;
      last_coarse <= last_coarse_nxt;
      last_fine   <= last_fine_nxt;
      err_timeout <= err_nxt;
    end
  end

  // Next-state and next-output decode; pulses default low, everything else holds.
  always_comb begin
    state_nxt       = state;
    d_nxt           = d;
    dcnt_nxt        = dcnt;
    runs_nxt        = runs;
    tcnt_nxt        = tcnt;
    start_nxt       = 1'b0;
    stop_nxt        = 1'b0;
    ack_nxt         = 1'b0;
    done_nxt        = 1'b0;
    running_nxt     = running;
    pass_nxt        = pass_count;
    fail_nxt        = fail_count;
    last_coarse_nxt = last_coarse;
    last_fine_nxt   = last_fine;
    err_nxt         = err_timeout;
    case (state)
      IDLE: begin
        if (go) begin
          d_nxt       = (delay_cfg == '0) ? ONE_C : delay_cfg;
          runs_nxt    = (num_runs == '0) ? ONE_R : num_runs;
          pass_nxt    = '0;
          fail_nxt    = '0;
          err_nxt     = 1'b0;
          running_nxt = 1'b1;
          state_nxt   = ARM;
        end
      end
      ARM: begin
        if (!tdc_busy && !tdc_valid) begin
          start_nxt = 1'b1;
          dcnt_nxt  = ONE_C;
          state_nxt = DELAY;
        end
      end
      DELAY: begin
        if (dcnt == d) begin
          stop_nxt  = 1'b1;
          tcnt_nxt  = '0;
          state_nxt = WAIT_VALID;
        end else begin
          dcnt_nxt = dcnt + ONE_C;
        end
      end
      WAIT_VALID: begin
        if (tdc_valid) begin
          last_coarse_nxt = tdc_coarse;
          last_fine_nxt   = tdc_fine;
          if (tdc_coarse == d - EXP_OFF) begin
            if (pass_count != 16'hFFFF) pass_nxt = pass_count + ONE_R;
          end else begin
            if (fail_count != 16'hFFFF) fail_nxt = fail_count + ONE_R;
          end
          ack_nxt   = 1'b1;
          state_nxt = NEXT;
        end else if (tcnt == T_LAST) begin
          err_nxt     = 1'b1;
          done_nxt    = 1'b1;
          running_nxt = 1'b0;
          state_nxt   = IDLE;
        end else begin
          tcnt_nxt = tcnt + ONE_T;
        end
      end
      NEXT: begin
        runs_nxt = runs - ONE_R;
`ifdef TDC_PULSE_GEN_SWEEP_EN
        if (d != '1) d_nxt = d + ONE_C;
`endif
        if (runs == ONE_R) begin
          done_nxt    = 1'b1;
          running_nxt = 1'b0;
          state_nxt   = IDLE;
        end else begin
          state_nxt = ARM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Bench for tdc_pulse_gen: a behavioural TDC model, a per-batch reference model
// feeding scoreboard queues, and a negedge monitor that pops and compares.
module tb_tdc_pulse_gen;
  localparam int CW  = 24;
  localparam int FW  = 8;
  localparam int OFF = 1;
  localparam int TO  = 40;

  typedef struct { logic [CW-1:0] coarse; logic [FW-1:0] fine; bit noresp; } plan_t;
  typedef struct { logic [CW-1:0] coarse; logic [FW-1:0] fine; } res_t;
  typedef struct { int pass; int fail; int err; } batch_t;

  logic clk_fast = 1'b0, rst = 1'b1, go = 1'b0;
  logic [CW-1:0] delay_cfg = '0;
  logic [15:0]   num_runs = '0;
  logic tdc_start, tdc_stop, tdc_ack;
  logic tdc_busy = 1'b0, tdc_valid = 1'b0;
  logic [CW-1:0] tdc_coarse = '0;
  logic [FW-1:0] tdc_fine = '0;
  logic running, done, err_timeout;
  logic [15:0] pass_count, fail_count;
  logic [CW-1:0] last_coarse;
  logic [FW-1:0] last_fine;

  plan_t  plan_q[$];
  res_t   result_q[$];
  int     spacing_q[$];
  batch_t done_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, st_cyc = 0, start_cnt = 0, done_cnt = 0;
  bit stale = 0;

  tdc_pulse_gen #(.COARSE_WIDTH(CW), .FINE_WIDTH(FW), .EXPECT_OFFSET(OFF), .TIMEOUT_CYCLES(TO)) dut (
    .clk_fast(clk_fast), .rst(rst), .go(go), .delay_cfg(delay_cfg), .num_runs(num_runs),
    .tdc_start(tdc_start), .tdc_stop(tdc_stop), .tdc_ack(tdc_ack),
    .tdc_busy(tdc_busy), .tdc_valid(tdc_valid), .tdc_coarse(tdc_coarse), .tdc_fine(tdc_fine),
    .running(running), .done(done), .pass_count(pass_count), .fail_count(fail_count),
    .last_coarse(last_coarse), .last_fine(last_fine), .err_timeout(err_timeout));

  always #5 clk_fast = ~clk_fast;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural TDC: busy between start and stop, result after a random latency,
  // valid held until acked.
  initial begin : tdc_model
    plan_t cur;
    res_t  r;
    int    lat;
    bit    pend, rv;
    pend = 0; rv = 0; lat = 0;
    cur = '{coarse: '0, fine: '0, noresp: 1'b0};
    forever begin
      @(posedge clk_fast); #1;
      if (rst) begin
        pend = 0; rv = 0; tdc_busy = 1'b0;
      end else begin
        if (tdc_ack) rv = 0;
        if (tdc_start) tdc_busy = 1'b1;
        if (tdc_stop) begin
          tdc_busy = 1'b0;
          if (plan_q.size() > 0) begin
            cur = plan_q.pop_front();
            if (!cur.noresp) begin pend = 1; lat = $urandom_range(0, 4); end
          end
        end else if (pend) begin
          if (lat == 0) begin
            rv = 1; pend = 0;
            tdc_coarse = cur.coarse; tdc_fine = cur.fine;
            r.coarse = cur.coarse; r.fine = cur.fine;
            result_q.push_back(r);
          end else lat--;
        end
      end
      tdc_valid = stale | rv;
    end
  end

  // Monitor: pops expectations whenever the DUT presents stop, ack or done.
  initial begin : monitor
    bit pv_busy, pv_valid;
    int sp;
    res_t r;
    batch_t b;
    pv_busy = 0; pv_valid = 0;
    forever begin
      @(negedge clk_fast);
      cyc++;
      if (!rst) begin
        if (tdc_start) begin
          chk("start_when_idle", {30'd0, pv_busy, pv_valid}, 32'd0);
          st_cyc = cyc; start_cnt++;
        end
        if (tdc_stop) begin
          if (spacing_q.size() == 0) chk("stop_unexpected", 32'd1, 32'd0);
          else begin sp = spacing_q.pop_front(); chk("stop_spacing", cyc - st_cyc, sp); end
        end
        if (tdc_ack) begin
          if (result_q.size() == 0) chk("ack_unrequested", 32'd1, 32'd0);
          else begin
            r = result_q.pop_front();
            chk("last_coarse", 32'(last_coarse), 32'(r.coarse));
            chk("last_fine", 32'(last_fine), 32'(r.fine));
          end
        end
        if (done) begin
          done_cnt++;
          if (done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
          else begin
            b = done_q.pop_front();
            chk("pass_count", 32'(pass_count), b.pass);
            chk("fail_count", 32'(fail_count), b.fail);
            chk("err_timeout", 32'(err_timeout), b.err);
            chk("running_at_done", 32'(running), 32'd0);
          end
        end
      end
      pv_busy = tdc_busy; pv_valid = tdc_valid;
    end
  end

  // Reference model of one batch: pushes stop spacings, TDC answers and the end result.
  // mode: 0 correct, 1 wrong, 2 random mix, 3 fixed value fv. to_run: run that times out (0 none).
  task automatic prepare(input int dcfg, input int nr, input int to_run, input int mode,
                         input logic [CW-1:0] fv, output int bound);
    logic [CW-1:0] dcur, expv;
    int rr, p, f, e;
    plan_t pl;
    batch_t b;
    dcur = (dcfg == 0) ? CW'(1) : CW'(dcfg);
    rr = (nr == 0) ? 1 : nr;
    p = 0; f = 0; e = 0; bound = TO + 60;
    for (int i = 1; i <= rr; i++) begin
      spacing_q.push_back(int'(dcur));
      bound += int'(dcur) + 12;
      expv = dcur - CW'(OFF);
      pl.fine = FW'($urandom);
      pl.noresp = 0;
      if (i == to_run) begin
        pl.noresp = 1; pl.coarse = '0; plan_q.push_back(pl); e = 1;
        break;
      end
      case (mode)
        0: pl.coarse = expv;
        1: pl.coarse = expv ^ CW'($urandom_range(1, 255));
        2: pl.coarse = ($urandom_range(0, 2) == 0) ? (expv ^ CW'($urandom_range(1, 255))) : expv;
        default: pl.coarse = fv;
      endcase
      plan_q.push_back(pl);
      if (pl.coarse == expv) p++; else f++;
`ifdef TDC_PULSE_GEN_SWEEP_EN
      if (dcur != '1) dcur = dcur + CW'(1);
`endif
    end
    b.pass = p; b.fail = f; b.err = e;
    done_q.push_back(b);
  endtask

  task automatic launch(input int dcfg, input int nr);
    @(posedge clk_fast); #1;
    delay_cfg = CW'(dcfg); num_runs = 16'(nr); go = 1'b1;
    @(posedge clk_fast); #1;
    go = 1'b0;
    delay_cfg = CW'($urandom); num_runs = 16'($urandom);
  endtask

  task automatic wait_done(input int bound);
    int target, n;
    target = done_cnt + 1; n = 0;
    while (done_cnt < target && n < bound) begin @(posedge clk_fast); n++; end
    chk("done_seen", 32'(done_cnt >= target), 32'd1);
    repeat (2) @(posedge clk_fast);
    #1;
  endtask

  task automatic batch(input int dcfg, input int nr, input int to_run, input int mode,
                       input logic [CW-1:0] fv);
    int bound;
    prepare(dcfg, nr, to_run, mode, fv, bound);
    launch(dcfg, nr);
    wait_done(bound);
  endtask

  initial begin : stimulus
    int bound, s0, n;
    #12;
    chk("rst_start", 32'(tdc_start), 0);
    chk("rst_stop", 32'(tdc_stop), 0);
    chk("rst_ack", 32'(tdc_ack), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_counts", {pass_count, fail_count}, 0);
    chk("rst_last", {last_coarse, last_fine}, 0);
    chk("rst_done_err", {30'd0, done, err_timeout}, 0);
    @(posedge clk_fast); #1 rst = 1'b0;

    batch(10, 1, 0, 0, '0);               // single run, passes
    batch(0, 0, 0, 3, CW'(5));            // zero clamps, mismatch with coarse 5
    batch(3, 4, 0, 0, '0);                // four passing runs
    batch(4, 3, 1, 0, '0);                // no response: timeout
    batch(2, 2, 0, 1, '0);                // clears err_timeout, both fail

    // Stale result held at go, plus a second go mid-batch.
    stale = 1;
    repeat (2) @(posedge clk_fast);
    prepare(6, 2, 0, 0, '0, bound);
    s0 = start_cnt;
    launch(6, 2);
    repeat (3) @(posedge clk_fast);
    launch(2, 9);
    repeat (5) @(posedge clk_fast);
    chk("stale_no_start", start_cnt, s0);
    chk("stale_running", 32'(running), 1);
    stale = 0;
    wait_done(bound + 20);

    for (int k = 0; k < 8; k++)
      batch($urandom_range(0, 12), $urandom_range(0, 5), 0, 2, '0);

    // Asynchronous reset in the middle of DELAY.
    prepare(20, 1, 0, 0, '0, bound);
    s0 = start_cnt;
    launch(20, 1);
    n = 0;
    while (start_cnt == s0 && n < 50) begin @(posedge clk_fast); n++; end
    chk("mid_start_seen", 32'(start_cnt != s0), 1);
    repeat (4) @(posedge clk_fast);
    chk("mid_running", 32'(running), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_pulses", {29'd0, tdc_start, tdc_stop, tdc_ack}, 0);
    chk("arst_running", 32'(running), 0);
    plan_q.delete(); result_q.delete(); spacing_q.delete(); done_q.delete();
    repeat (2) @(posedge clk_fast);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk_fast);
    #1;
    chk("post_rst_idle", {30'd0, running, tdc_start}, 0);
    batch(5, 3, 0, 0, '0);

    chk("queues_empty", plan_q.size() + result_q.size() + spacing_q.size() + done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
